// File: rtl/packet_splitter.sv
// Serialises one message plus its CRC-8 into bytes, LSB byte first, for the UART TX byte engine.
// The CRC is computed one byte per cycle before the first byte is offered.
module packet_splitter #(
    parameter int unsigned DATA_LENGTH    = 8,
    parameter int unsigned MESSAGE_LENGTH = 48,
    parameter int unsigned CRC_LENGTH     = 8,
    parameter logic [CRC_LENGTH-1:0] CRC_POLY = 8'h07
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [MESSAGE_LENGTH-1:0] msg_data,
    input  logic                      msg_valid,
    output logic                      msg_ready,
    output logic [DATA_LENGTH-1:0]    tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      busy
);

    localparam int unsigned SEGMENT_COUNT = (MESSAGE_LENGTH + CRC_LENGTH) / DATA_LENGTH;
    localparam int unsigned MSG_BYTES     = MESSAGE_LENGTH / DATA_LENGTH;
    localparam int unsigned SEG_W         = $clog2(SEGMENT_COUNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [MESSAGE_LENGTH-1:0] msg_q, msg_d;
    logic [CRC_LENGTH-1:0]     crc_q, crc_d;
    logic [SEG_W-1:0]          idx_q, idx_d;
    logic [SEG_W-1:0]          seg_q, seg_d;
    logic [SEG_W-1:0]          seg_nxt;
    logic [DATA_LENGTH-1:0]    tx_data_d;
    logic                      tx_valid_d;
    logic [DATA_LENGTH-1:0]    pkt_bytes [SEGMENT_COUNT];

    // One CRC-8 update over a whole byte, MSB first, no reflection.
    function automatic logic [CRC_LENGTH-1:0] crc8_step(input logic [CRC_LENGTH-1:0] crc,
                                                        input logic [DATA_LENGTH-1:0] data);
        logic [CRC_LENGTH-1:0] c;
        c = crc ^ data;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            c = c[CRC_LENGTH-1] ? ({c[CRC_LENGTH-2:0], 1'b0} ^ CRC_POLY) : {c[CRC_LENGTH-2:0], 1'b0};
        end
        return c;
    endfunction

    // Packet view: message bytes followed by the CRC byte at the top.
    always_comb begin
        for (int k = 0; k < MSG_BYTES; k++) begin
            pkt_bytes[k] = msg_q[k*DATA_LENGTH +: DATA_LENGTH];
        end
        pkt_bytes[SEGMENT_COUNT-1] = crc_q;
    end

    assign seg_nxt   = seg_q + SEG_W'(1);
    assign msg_ready = (state_q == IDLE) && !reset;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            msg_q    <= '0;
            crc_q    <= '0;
            idx_q    <= '0;
            seg_q    <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            crc_q    <= crc_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            tx_data  <= tx_data_d;
            tx_valid <= tx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        crc_d      = crc_q;
        idx_d      = idx_q;
        seg_d      = seg_q;
        tx_data_d  = tx_data;
        tx_valid_d = tx_valid;

        case (state_q)
            IDLE: begin
                if (msg_valid && msg_ready) begin
                    msg_d   = msg_data;
                    crc_d   = '0;
                    idx_d   = SEG_W'(MSG_BYTES - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                // Highest message byte first so the CRC sees bits MSB first.
                crc_d = crc8_step(crc_q, pkt_bytes[idx_q]);
                if (idx_q == '0) begin
                    seg_d      = '0;
                    tx_data_d  = pkt_bytes[0];
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end else begin
                    idx_d = idx_q - SEG_W'(1);
                end
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    if (seg_q == SEG_W'(SEGMENT_COUNT - 1)) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        seg_d     = seg_nxt;
                        tx_data_d = pkt_bytes[seg_nxt];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_packet_splitter.sv
// Scoreboard bench for packet_splitter: expected bytes queued at issue time, popped by a monitor.
module tb_packet_splitter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] msg_data = '0;
    logic        msg_valid = 1'b0;
    logic        msg_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;

    int          n_tests = 0;
    int          n_fail = 0;
    int          bytes_out = 0;
    int          duty = 100;
    logic [7:0]  exp_q[$];

    packet_splitter dut (
        .clk       (clk),
        .reset     (reset),
        .msg_data  (msg_data),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference CRC: long division of the 48-bit message, one bit at a time.
    function automatic logic [7:0] ref_crc(input logic [47:0] m);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 47; i >= 0; i--) begin
            fb = c[7] ^ m[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic push_packet(input logic [55:0] p);
        for (int k = 0; k < 7; k++) exp_q.push_back(p[8*k +: 8]);
    endtask

    task automatic push_model(input logic [47:0] m);
        push_packet({ref_crc(m), m});
    endtask

    // Wait for msg_ready, present the message, return just after the accept edge.
    task automatic send(input logic [47:0] m);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (msg_ready) begin ok = 1; break; end
        end
        if (!ok) check("send_wait_ready", 64'(0), 64'(1));
        msg_data  = m;
        msg_valid = 1'b1;
        @(posedge clk);
        #1 msg_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && msg_ready) begin ok = 1; break; end
        end
        check(name, 64'(ok), 64'(1));
    endtask

    task automatic run_random(input int n);
        logic [47:0] m;
        for (int i = 0; i < n; i++) begin
            m = 48'({$urandom(), $urandom()});
            push_model(m);
            send(m);
        end
        drain("drain_random");
    endtask

    // tx_ready driver with adjustable duty cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1 tx_ready = ($urandom_range(0, 99) < duty);
        end
    end

    // Monitor: scoreboard pop on handshake, stall stability, busy/msg_ready relation.
    initial begin
        bit         prev_stall = 0;
        logic [7:0] prev_data = '0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("ready_vs_busy", 64'(msg_ready), 64'(!busy));
                if (prev_stall) begin
                    check("stall_valid", 64'(tx_valid), 64'(1));
                    check("stall_data", 64'(tx_data), 64'(prev_data));
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", 64'(tx_data), 64'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", 64'(tx_data), 64'(e));
                    end
                    bytes_out++;
                end
            end
            prev_stall = !reset && tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int base;
        bit ok;
        logic [47:0] a;
        logic [47:0] b;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_msg_ready", 64'(msg_ready), 64'(0));
        check("rst_tx_valid", 64'(tx_valid), 64'(0));
        check("rst_tx_data", 64'(tx_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_msg_ready", 64'(msg_ready), 64'(1));

        // Test 1: single set bit, with latency measurement
        duty = 100;
        repeat (2) @(posedge clk);
        push_packet(56'h07_0000_0000_0001);
        send(48'h0000_0000_0001);
        n = 0;
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_valid) begin ok = 1; break; end
            @(posedge clk);
            n++;
        end
        check("t1_tx_valid_seen", 64'(ok), 64'(1));
        check("t1_first_valid_edge", 64'(n), 64'(6));
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (msg_ready) begin ok = 1; break; end
        end
        check("t1_ready_seen", 64'(ok), 64'(1));
        check("t1_ready_return_edge", 64'(n), 64'(13));
        drain("t1_drain");

        // Test 2: all-zero message
        push_packet(56'h0);
        send(48'h0);
        drain("t2_drain");

        // Test 3: 0x80 gives CRC 0x89
        push_packet(56'h89_0000_0000_0080);
        send(48'h0000_0000_0080);
        drain("t3_drain");

        // Test 4: known pattern under backpressure
        duty = 30;
        push_model(48'h1122_3344_5566);
        send(48'h1122_3344_5566);
        drain("t4_drain");
        run_random(6);

        // Test 5: msg_valid held high across two messages
        duty = 100;
        a = 48'({$urandom(), $urandom()});
        b = 48'({$urandom(), $urandom()});
        base = bytes_out;
        push_model(a);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (msg_ready) begin ok = 1; break; end
        end
        msg_data  = a;
        msg_valid = 1'b1;
        @(posedge clk);
        #1 msg_data = b;
        push_model(b);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (msg_ready) begin ok = 1; break; end
        end
        check("t5_second_ready", 64'(ok), 64'(1));
        check("t5_bytes_before_second", 64'(bytes_out - base), 64'(7));
        @(posedge clk);
        #1 msg_valid = 1'b0;
        drain("t5_drain");
        check("t5_total_bytes", 64'(bytes_out - base), 64'(14));

        // Test 6: reset after the third byte
        base = bytes_out;
        a = 48'({$urandom(), $urandom()});
        push_model(a);
        send(a);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (bytes_out >= base + 3) begin ok = 1; break; end
        end
        check("t6_three_bytes", 64'(ok), 64'(1));
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("t6_tx_valid_after_rst", 64'(tx_valid), 64'(0));
        check("t6_busy_after_rst", 64'(busy), 64'(0));
        check("t6_ready_in_rst", 64'(msg_ready), 64'(0));
        check("t6_bytes_at_abort", 64'(bytes_out - base), 64'(3));
        @(posedge clk);
        #1 reset = 1'b0;
        base = bytes_out;
        b = 48'({$urandom(), $urandom()});
        push_model(b);
        send(b);
        drain("t6_drain");
        check("t6_full_packet", 64'(bytes_out - base), 64'(7));

        // Random tail with mixed backpressure
        duty = 60;
        run_random(8);
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
